// File: rtl/alpu_mw_seq.sv
// Multi-word sequential ALPU: one REG_WIDTH slice per cycle, LSB slice first,
// with the slice carry rippled through a register between cycles.
module alpu_mw_seq #(
   parameter int REG_WIDTH = 16,
   parameter int NWORDS    = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NWORDS*REG_WIDTH-1:0]   in_a,
   input  logic [NWORDS*REG_WIDTH-1:0]   in_b,
   input  logic [7:0]                    in_ctrl,
   input  logic                          in_cin,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NWORDS*REG_WIDTH-1:0]   out_result,
   output logic                          out_cout,
   output logic                          out_zero
);

   localparam int W  = NWORDS * REG_WIDTH;
   localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [W-1:0]           a_q;
   logic [W-1:0]           b_q;
   logic [7:0]             ctrl_q;
   logic [CW-1:0]          cnt;
   logic                   carry_q;
   logic [W-1:0]           res_q;
   logic [W-1:0]           res_nxt;

   int                     off;
   logic [REG_WIDTH-1:0]   a_s;
   logic [REG_WIDTH-1:0]   b_s;
   logic [REG_WIDTH-1:0]   ap;
   logic [REG_WIDTH-1:0]   bp;
   logic [REG_WIDTH-1:0]   x;
   logic [REG_WIDTH-1:0]   g;
   logic [REG_WIDTH-1:0]   s;
   logic [REG_WIDTH-1:0]   r;
   logic                   c;
   logic                   last;

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign out_result = res_q;
   assign last       = (cnt == LAST);

   // Slice datapath for the slice selected by cnt
   always_comb begin
      off = int'(cnt) * REG_WIDTH;
      a_s = a_q[off +: REG_WIDTH];
      b_s = b_q[off +: REG_WIDTH];
      ap  = a_s ^ {REG_WIDTH{ctrl_q[7] | ctrl_q[6]}};
      bp  = b_s & {REG_WIDTH{~ctrl_q[6]}};
      x   = ap ^ bp;
      g   = (ap & bp & {REG_WIDTH{ctrl_q[5]}})
          | (x & {REG_WIDTH{ctrl_q[4]}});
      s   = '0;
      c   = carry_q;
      for (int i = 0; i < REG_WIDTH; i++) begin
         s[i] = x[i] ^ (c & ctrl_q[3]);
         c    = ctrl_q[3] & (g[i] | (x[i] & c));
      end
      r   = ((s & {REG_WIDTH{ctrl_q[2]}})
          | (g & {REG_WIDTH{ctrl_q[1]}}))
          ^ {REG_WIDTH{ctrl_q[0]}};
      res_nxt = res_q;
      res_nxt[off +: REG_WIDTH] = r;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid) state_nxt = EXEC;
         EXEC:    if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         cnt      <= '0;
         carry_q  <= 1'b0;
         res_q    <= '0;
         out_cout <= 1'b0;
         out_zero <= 1'b0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= in_a;
                  b_q     <= in_b;
                  ctrl_q  <= in_ctrl;
                  cnt     <= '0;
                  // negate-A's +1 rides in on the slice-0 carry
                  carry_q <= in_cin | in_ctrl[7];
               end
            end
            EXEC: begin
               res_q   <= res_nxt;
               carry_q <= c;
               if (last) begin
                  cnt      <= '0;
                  out_zero <= ~|res_nxt;
                  out_cout <= c;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alpu_mw_seq.sv
// Directed bench for alpu_mw_seq (REG_WIDTH=16, NWORDS=4).
// Expected values are hand-computed constants.
module tb_alpu_mw_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic [7:0]  in_ctrl;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic        out_cout;
   logic        out_zero;

   int n_cmp = 0;
   int n_bad = 0;
   int lat;
   logic [63:0] held;

   alpu_mw_seq #(.REG_WIDTH(16), .NWORDS(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_ctrl    (in_ctrl),
      .in_cin     (in_cin),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_cout   (out_cout),
      .out_zero   (out_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op; returns with out_valid high (or bound expired),
   // sampled 1 time unit after the edge. lat counts cycles from the
   // request cycle to the first out_valid cycle.
   task automatic issue(input logic [7:0] c, input logic [63:0] a,
                        input logic [63:0] b, input logic ci,
                        output int l);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b1;
      in_ctrl  = c;
      in_a     = a;
      in_b     = b;
      in_cin   = ci;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = ~a;
      in_b     = ~b;
      in_ctrl  = ~c;
      in_cin   = ~ci;
      l = 1;
      while (!out_valid && l < 50) begin
         @(posedge clk);
         #1;
         l++;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run(input string tag, input logic [7:0] c,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic ci, input logic [63:0] er,
                      input logic ec, input logic ez);
      int l;
      issue(c, a, b, ci, l);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_res"}, out_result, er);
      chk({tag, "_cout"}, 64'(out_cout), 64'(ec));
      chk({tag, "_zero"}, 64'(out_zero), 64'(ez));
      consume();
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_ctrl   = '0;
      in_cin    = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_res", out_result, 64'd0);
      chk("rst_cout", 64'(out_cout), 64'd0);
      chk("rst_zero", 64'(out_zero), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // ADD with carry across slice 1 -> 2, plus latency
      issue(8'h2C, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, lat);
      chk("add_lat", 64'(lat), 64'd5);
      chk("add_res", out_result, 64'h0000_0001_0000_0000);
      chk("add_cout", 64'(out_cout), 64'd0);
      chk("add_zero", 64'(out_zero), 64'd0);
      consume();

      run("sub1", 8'hAC, 64'h1, 64'h0, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      run("sub0", 8'hAC, 64'h1234_5678_9ABC_DEF0,
          64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0, 1'b1, 1'b1);
      run("addff", 8'h2C, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

      run("and", 8'h22, 64'hF0F0_00FF_1234_AAAA,
          64'hFF00_0F0F_4321_5555, 1'b0,
          64'hF000_000F_0220_0000, 1'b0, 1'b0);
      run("or", 8'h32, 64'hF0F0_00FF_1234_AAAA,
          64'hFF00_0F0F_4321_5555, 1'b0,
          64'hFFF0_0FFF_5335_FFFF, 1'b0, 1'b0);
      run("xor", 8'h04, 64'hF0F0_00FF_1234_AAAA,
          64'hFF00_0F0F_4321_5555, 1'b0,
          64'h0FF0_0FF0_5115_FFFF, 1'b0, 1'b0);
      run("nota", 8'h44, 64'hF0F0_00FF_1234_AAAA,
          64'hFF00_0F0F_4321_5555, 1'b1,
          64'h0F0F_FF00_EDCB_5555, 1'b0, 1'b0);

      // Backpressure: DONE holds while new requests are waved at it
      issue(8'h2C, 64'h1111, 64'h2222, 1'b0, lat);
      chk("bp_res0", out_result, 64'h3333);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         in_a     = {$urandom, $urandom};
         in_b     = {$urandom, $urandom};
         in_ctrl  = 8'($urandom);
         @(posedge clk);
         #1;
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_ready", 64'(in_ready), 64'd0);
         chk("bp_res", out_result, 64'h3333);
         chk("bp_cout", 64'(out_cout), 64'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      consume();
      chk("bp_rel_ready", 64'(in_ready), 64'd1);
      chk("bp_rel_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("bp_no_cap", 64'(in_ready), 64'd1);

      // Reset in the middle of EXEC, after slice 2 is written
      @(negedge clk);
      in_valid = 1'b1;
      in_ctrl  = 8'h2C;
      in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
      in_b     = 64'h1;
      in_cin   = 1'b0;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("exec_ready", 64'(in_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("exec_valid", 64'(out_valid), 64'd0);
      reset_n = 1'b0;
      #1;
      chk("abort_valid", 64'(out_valid), 64'd0);
      chk("abort_ready", 64'(in_ready), 64'd1);
      chk("abort_res", out_result, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run("post_add", 8'h2C, 64'd2, 64'd3, 1'b0, 64'd5, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alpu_mw_seq.md
# alpu_mw_seq

Multi-word sequential ALPU. Runs one arithmetic/logic operation on operands of NWORDS×REG_WIDTH bits, one REG_WIDTH slice per cycle from least-significant upward, carrying each slice's carry-out into the next slice. It sits in the exec unit beside the single-cycle ALPU and serves wide operands with one narrow datapath. It has valid/ready handshakes on both sides and registered result and flags.

## Interface
Parameters:
- REG_WIDTH, 16, slice width in bits (≥2).
- NWORDS, 4, number of slices per operand (≥1). Operand width W = NWORDS×REG_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_ctrl  in  8  operation control word, encoding below.
- in_cin  in  1  external carry-in to slice 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  W  result.
- out_cout  out  1  carry-out of slice NWORDS-1.
- out_zero  out  1  out_result == 0.

## Operation
- Per-slice datapath, all bits i of the slice:
  - a' = a ^ (ctrl[7] | ctrl[6]); b' = b & ~ctrl[6]
  - x = a' ^ b'; g = (a' & b' & ctrl[5]) | (x & ctrl[4])
  - Carry chain: c0 = slice carry-in; c(i+1) = g | (x & c(i)) when ctrl[3]=1, else 0. Slice cout = c(REG_WIDTH) when ctrl[3]=1, else 0.
  - s = x ^ (c(i) & ctrl[3]); r = ((s & ctrl[2]) | (g & ctrl[1])) ^ ctrl[0]
- ctrl[7] is two's-complement negate of A. In this block it is the bit inversion above plus a +1 injected on slice 0: slice-0 carry-in = in_cin | ctrl[7]. ctrl[7] gives a correct negation only with ctrl[3]=1.
- Slice k>0 carry-in = registered cout of slice k-1.
- Reference encodings: ADD 0x2C, SUB (B−A) 0xAC, AND 0x22, OR 0x32, XOR 0x04, NOT A 0x44.
- State machine:
  - IDLE: in_ready=1. On in_valid, capture in_a, in_b, in_ctrl and in_cin. Clear the slice counter. Go to EXEC.
  - EXEC: each cycle, compute the slice at counter k, write it to result bits [k·RW +: RW], register the slice cout and increment k. After slice NWORDS-1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ctrl, in_a, in_b and in_cin are sampled only on the accepting edge. Later input changes have no effect on the operation in flight.
- out_zero and out_cout are updated on the edge that writes the final slice.

## Timing
- Reset (async assert, sync-safe deassert) gives:
  - state=IDLE, in_ready=1, out_valid=0
  - out_result=0, out_cout=0, out_zero=0
  - counter=0 and the internal carry register cleared.
- Accept on edge E. Slices are written on edges E+1 … E+NWORDS. out_valid rises after edge E+NWORDS.
- Latency is NWORDS+1 cycles from acceptance to out_valid. Throughput is one op per NWORDS+2 cycles minimum (one IDLE cycle after each result handshake).
- in_ready is 0 throughout EXEC and DONE. A request presented then is not accepted and must be held by the producer.
- While out_valid=1 and out_ready=0, out_result, out_cout and out_zero hold stable.
- out_ready=1 on the cycle out_valid rises completes the handshake on that edge.
- out_ready asserted while out_valid=0 is ignored.
- NWORDS=1 degenerates to a one-slice EXEC (latency 2).
- Counter width is clog2(NWORDS), minimum 1. The counter never wraps inside an operation.
- Reset asserted mid-EXEC or in DONE aborts the operation immediately. The partial result is discarded and outputs return to reset values.

## Test plan
- ADD, NWORDS=4, A=0x0000_0000_FFFF_FFFF, B=0x1, cin=0 → result 0x0000_0001_0000_0000, cout=0, zero=0, out_valid exactly 5 cycles after acceptance.
- SUB 0xAC, A=0x1, B=0x0 → result 0xFFFF_FFFF_FFFF_FFFF, cout=0. Then A=B=0x1234_5678_9ABC_DEF0 → result 0, zero=1, cout=1.
- ADD, A=B=0xFFFF_FFFF_FFFF_FFFF, cin=1 → result 0xFFFF_FFFF_FFFF_FFFF, cout=1. Checks carry propagation across all four slice boundaries.
- Logic ops on A=0xF0F0_00FF_1234_AAAA, B=0xFF00_0F0F_4321_5555, checked against a bit-level model:
  - AND → 0xF000_000F_0220_0000
  - OR → 0xFFF0_0FFF_5335_FFFF
  - XOR → 0x0FF0_0FF0_5115_FFFF
  - NOT A → 0x0F0F_FF00_EDCB_5555
  - cout=0 for all four.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid while toggling in_valid and operands → outputs stable, in_ready=0, no second capture. Then out_ready=1 for one cycle → in_ready=1 on the following cycle.
- Assert reset_n=0 for one cycle mid-EXEC (after slice 2) → out_valid=0, in_ready=1, out_result=0. A new ADD 2+3 issued afterwards completes with result 5.
